vga_fb_scanout: RTL and testbench

//  Read side of the 160x120x12-bit pixel framebuffer that the drawing engines write via CounterX/CounterY/color.

---
 rtl/vga_fb_scanout.sv | 216 +++++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout.sv
// -----------------------------------------------------------------------------
// vga_fb_scanout
//
// Read side of a 160x120x12-bit framebuffer. Generates 640x480@60 VGA timing
// from clk with a pixel-clock enable, reads the framebuffer with 4x pixel
// replication and drives RGB444 plus active-low hsync/vsync. Colour and both
// syncs of a pixel leave on the same clk edge.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   rd_en        out  framebuffer read strobe, one clk per visible pixel
//   rd_addr      out  framebuffer word address y*FB_W + x (holds between reads)
//   rd_data      in   pixel {R[11:8],G[7:4],B[3:0]}, valid RAM_LAT clk after rd_en
//   vga_r/g/b    out  colour, forced to 0 during blanking
//   vga_hs       out  horizontal sync, active low
//   vga_vs       out  vertical sync, active low
//   frame_start  out  one-clk pulse when the scan counters wrap to (0,0)
// -----------------------------------------------------------------------------
module vga_fb_scanout #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int RAM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rd_en,
    output logic [14:0] rd_addr,
    input  logic [11:0] rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0]      FB_W15   = 15'(FB_W);
    localparam logic [14:0]      FB_Y_MAX = 15'(FB_H - 1);

    // Scan generator state
    logic [DIV_W-1:0] div_q, div_d;
    logic [HW-1:0]    h_cnt_q, h_cnt_d;
    logic [VW-1:0]    v_cnt_q, v_cnt_d;
    logic             frame_start_q, frame_start_d;

    // Stage 1: read request plus the pixel's flags, captured on the tick edge
    logic             rd_en_q, rd_en_d;
    logic [14:0]      rd_addr_q, rd_addr_d;
    logic             vis_s1_q, vis_s1_d;
    logic             hs_s1_q, hs_s1_d;
    logic             vs_s1_q, vs_s1_d;

    // Delay line matching the framebuffer read latency
    logic [RAM_LAT-1:0] stb_pipe_q, stb_pipe_d;
    logic [RAM_LAT-1:0] vis_pipe_q, vis_pipe_d;
    logic [RAM_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [RAM_LAT-1:0] vs_pipe_q, vs_pipe_d;

    // Pin registers
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    logic             tick;
    logic             visible;
    logic             hs_now;
    logic             vs_now;
    logic [14:0]      fb_x;
    logic [14:0]      fb_y_raw;
    logic [14:0]      fb_y;

    // NOTE: every signal assigned in always_comb gets a default at the top of
    // the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        tick    = (div_q == DIV_LAST);
        visible = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_now  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_now  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

        div_d         = tick ? '0 : div_q + 1'b1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        // Pixel replication is just dropping the low coordinate bits. The y
        // clamp only matters if the timing parameters outgrow the framebuffer.
        fb_x     = 15'(h_cnt_q >> SCALE_SH);
        fb_y_raw = 15'(v_cnt_q >> SCALE_SH);
        fb_y     = (fb_y_raw > FB_Y_MAX) ? FB_Y_MAX : fb_y_raw;

        rd_en_d   = tick && visible;
        rd_addr_d = rd_en_d ? (fb_y * FB_W15 + fb_x) : rd_addr_q;

        // Flags are held between ticks so that the free-running delay line
        // below presents a stable value for the whole pixel period.
        vis_s1_d = tick ? visible : vis_s1_q;
        hs_s1_d  = tick ? hs_now  : hs_s1_q;
        vs_s1_d  = tick ? vs_now  : vs_s1_q;

        stb_pipe_d    = stb_pipe_q;
        vis_pipe_d    = vis_pipe_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        stb_pipe_d[0] = rd_en_q;
        vis_pipe_d[0] = vis_s1_q;
        hs_pipe_d[0]  = hs_s1_q;
        vs_pipe_d[0]  = vs_s1_q;
        for (int i = 1; i < RAM_LAT; i++) begin
            stb_pipe_d[i] = stb_pipe_q[i-1];
            vis_pipe_d[i] = vis_pipe_q[i-1];
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
        end

        // rd_data is only meaningful on the strobe clk; hold it otherwise and
        // blank whenever the delayed pixel was outside the active area.
        if (!vis_pipe_q[RAM_LAT-1]) begin
            rgb_d = 12'h000;
        end else if (stb_pipe_q[RAM_LAT-1]) begin
            rgb_d = rd_data;
        end else begin
            rgb_d = rgb_q;
        end
        hs_d = hs_pipe_q[RAM_LAT-1];
        vs_d = vs_pipe_q[RAM_LAT-1];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            vis_s1_q      <= 1'b0;
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            stb_pipe_q    <= '0;
            vis_pipe_q    <= '0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            vis_s1_q      <= vis_s1_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            stb_pipe_q    <= stb_pipe_d;
            vis_pipe_q    <= vis_pipe_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_scanout
//
// Three instances share clk/rst:
//   u_full : full 640x480 timing, RAM returns addr[11:0] one clk after rd_en.
//   u_s1   : shrunken timing (24x12 scan, 4x2 framebuffer), RAM_LAT=1.
//   u_s2   : same shrunken timing, RAM_LAT=2.
// The shrunken instances are compared every clk against a closed-form model
// that derives the expected pins from the number of clk edges since reset.
// Their RAM drives 12'hFFF whenever its read data is not valid.
// -----------------------------------------------------------------------------
module tb_vga_fb_scanout;

    localparam int S_PD  = 2;
    localparam int S_HA  = 16;
    localparam int S_HFP = 2;
    localparam int S_HS  = 3;
    localparam int S_HBP = 3;
    localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;   // 24
    localparam int S_VA  = 8;
    localparam int S_VFP = 1;
    localparam int S_VS  = 2;
    localparam int S_VBP = 1;
    localparam int S_VT  = S_VA + S_VFP + S_VS + S_VBP;   // 12
    localparam int S_FBW = 4;
    localparam int S_FBH = 2;
    localparam int S_SH  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n = 0;            // clk edges since reset release
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // ---------------- full-size instance ----------------
    logic        rd_en_f, vga_hs_f, vga_vs_f, fs_f;
    logic [14:0] rd_addr_f;
    logic [11:0] rd_data_f = 12'h000;
    logic [3:0]  r_f, g_f, b_f;

    vga_fb_scanout u_full (
        .clk(clk), .rst(rst), .rd_en(rd_en_f), .rd_addr(rd_addr_f), .rd_data(rd_data_f),
        .vga_r(r_f), .vga_g(g_f), .vga_b(b_f), .vga_hs(vga_hs_f), .vga_vs(vga_vs_f),
        .frame_start(fs_f)
    );

    always @(posedge clk) if (rd_en_f) rd_data_f <= rd_addr_f[11:0];

    // ---------------- shrunken instances ----------------
    logic        rd_en_s1, hs_s1, vs_s1, fs_s1;
    logic        rd_en_s2, hs_s2, vs_s2, fs_s2;
    logic [14:0] rd_addr_s1, rd_addr_s2;
    logic [11:0] rd_data_s1, rd_data_s2;
    logic [3:0]  r_s1, g_s1, b_s1, r_s2, g_s2, b_s2;
    logic [11:0] mem [8];

    vga_fb_scanout #(
        .PIX_DIV(S_PD), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .FB_W(S_FBW), .FB_H(S_FBH), .SCALE_SH(S_SH), .RAM_LAT(1)
    ) u_s1 (
        .clk(clk), .rst(rst), .rd_en(rd_en_s1), .rd_addr(rd_addr_s1), .rd_data(rd_data_s1),
        .vga_r(r_s1), .vga_g(g_s1), .vga_b(b_s1), .vga_hs(hs_s1), .vga_vs(vs_s1),
        .frame_start(fs_s1)
    );

    vga_fb_scanout #(
        .PIX_DIV(S_PD), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .FB_W(S_FBW), .FB_H(S_FBH), .SCALE_SH(S_SH), .RAM_LAT(2)
    ) u_s2 (
        .clk(clk), .rst(rst), .rd_en(rd_en_s2), .rd_addr(rd_addr_s2), .rd_data(rd_data_s2),
        .vga_r(r_s2), .vga_g(g_s2), .vga_b(b_s2), .vga_hs(hs_s2), .vga_vs(vs_s2),
        .frame_start(fs_s2)
    );

    // RAM models: data valid only in the clk RAM_LAT after rd_en, else 12'hFFF
    logic        v1 = 1'b0;
    logic [11:0] d1 = 12'h000;
    logic [1:0]  v2 = 2'b00;
    logic [11:0] d2a = 12'h000, d2b = 12'h000;

    always @(posedge clk) begin
        v1  <= rd_en_s1;
        d1  <= mem[rd_addr_s1[2:0]];
        v2  <= {v2[0], rd_en_s2};
        d2a <= mem[rd_addr_s2[2:0]];
        d2b <= d2a;
    end
    assign rd_data_s1 = v1    ? d1  : 12'hFFF;
    assign rd_data_s2 = v2[1] ? d2b : 12'hFFF;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (n=%0d, t=%0t)", name, got, exp, n, $time);
        end
    endtask

    // ---------------- behavioural model (shrunken timing) ----------------
    // Pixel k is ticked on edge S_PD*(k+1); its pins appear lat edges later.
    function automatic int pix_at(int cnt, int lat);
        if (cnt - lat < S_PD) return -1;
        return (cnt - lat) / S_PD - 1;
    endfunction

    function automatic int px_h(int k); return k % S_HT; endfunction
    function automatic int px_v(int k); return (k / S_HT) % S_VT; endfunction
    function automatic bit px_vis(int k);
        return (px_h(k) < S_HA) && (px_v(k) < S_VA);
    endfunction
    function automatic int fb_addr(int h, int v);
        return (v >> S_SH) * S_FBW + (h >> S_SH);
    endfunction

    function automatic int m_rgb(int cnt, int lat);
        int k = pix_at(cnt, lat);
        if (k < 0 || !px_vis(k)) return 0;
        return int'(mem[fb_addr(px_h(k), px_v(k))]);
    endfunction

    function automatic int m_hs(int cnt, int lat);
        int k = pix_at(cnt, lat);
        if (k < 0) return 1;
        return (px_h(k) >= S_HA + S_HFP && px_h(k) < S_HA + S_HFP + S_HS) ? 0 : 1;
    endfunction

    function automatic int m_vs(int cnt, int lat);
        int k = pix_at(cnt, lat);
        if (k < 0) return 1;
        return (px_v(k) >= S_VA + S_VFP && px_v(k) < S_VA + S_VFP + S_VS) ? 0 : 1;
    endfunction

    function automatic int m_rd_en(int cnt);
        if (cnt < S_PD || (cnt % S_PD) != 0) return 0;
        return px_vis(cnt / S_PD - 1) ? 1 : 0;
    endfunction

    // Address of the most recent visible pixel read so far
    function automatic int m_addr(int cnt);
        int k = pix_at(cnt, 0);
        int h, v;
        if (k < 0) return 0;
        h = px_h(k);
        v = px_v(k);
        if (v >= S_VA) return fb_addr(S_HA - 1, S_VA - 1);
        if (h >= S_HA) return fb_addr(S_HA - 1, v);
        return fb_addr(h, v);
    endfunction

    function automatic int m_fs(int cnt);
        if (cnt < S_PD || (cnt % S_PD) != 0) return 0;
        return ((cnt / S_PD) % (S_HT * S_VT) == 0) ? 1 : 0;
    endfunction

    task automatic compare_dut(input string tag, input int lat, input logic [11:0] rgb,
                               input logic hs, input logic vs, input logic rden,
                               input logic [14:0] addr, input logic fs);
        check({tag, "_rgb"},     32'(rgb),  32'(m_rgb(n, lat)));
        check({tag, "_hs"},      32'(hs),   32'(m_hs(n, lat)));
        check({tag, "_vs"},      32'(vs),   32'(m_vs(n, lat)));
        check({tag, "_rd_en"},   32'(rden), 32'(m_rd_en(n)));
        check({tag, "_rd_addr"}, 32'(addr), 32'(m_addr(n)));
        check({tag, "_fs"},      32'(fs),   32'(m_fs(n)));
    endtask

    task automatic check_reset(input string tag, input logic [11:0] rgb, input logic hs,
                               input logic vs, input logic rden, input logic [14:0] addr,
                               input logic fs);
        check({tag, "_rst_rgb"},   32'(rgb),  32'h000);
        check({tag, "_rst_hs"},    32'(hs),   32'h1);
        check({tag, "_rst_vs"},    32'(vs),   32'h1);
        check({tag, "_rst_rd_en"}, 32'(rden), 32'h0);
        check({tag, "_rst_addr"},  32'(addr), 32'h0);
        check({tag, "_rst_fs"},    32'(fs),   32'h0);
    endtask

    // The single per-cycle compare process for the modelled instances
    always @(negedge clk) begin
        compare_dut("s1", 2, {r_s1, g_s1, b_s1}, hs_s1, vs_s1, rd_en_s1, rd_addr_s1, fs_s1);
        compare_dut("s2", 3, {r_s2, g_s2, b_s2}, hs_s2, vs_s2, rd_en_s2, rd_addr_s2, fs_s2);
    end

    // rd_en census over the first frame after the second reset release
    bit second_run = 1'b0;
    int rden_cnt = 0;
    int addr_cnt [8] = '{default: 0};
    int bad_addr = 0;

    always @(negedge clk) begin
        if (second_run && !rst && n >= 1 && n <= S_PD * S_HT * S_VT && rd_en_s1) begin
            rden_cnt <= rden_cnt + 1;
            if (rd_addr_s1 < 15'd8) addr_cnt[int'(rd_addr_s1)] <= addr_cnt[int'(rd_addr_s1)] + 1;
            else                    bad_addr <= bad_addr + 1;
        end
    end

    // hsync edge monitor for the full-size instance
    int   hs_fall_q[$];
    int   hs_rise_q[$];
    logic prev_hs_f = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            hs_fall_q.delete();
            hs_rise_q.delete();
            prev_hs_f <= 1'b1;
        end else begin
            if (prev_hs_f && !vga_hs_f) hs_fall_q.push_back(n);
            if (!prev_hs_f && vga_hs_f) hs_rise_q.push_back(n);
            prev_hs_f <= vga_hs_f;
        end
    end

    function automatic int q_at(input int q[$], input int idx);
        if (idx >= q.size()) return -1;
        return q[idx];
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (n=%0d)", n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 12'(12'h111 * (i + 1));
        rst = 1'b1;

        // Hand-computed pins for the model itself
        check("pin_rgb_v4_h0",    32'(m_rgb(196, 2)), 32'h555);
        check("pin_rgb_blank",    32'(m_rgb(195, 2)), 32'h000);
        check("pin_addr_visible", 32'(m_addr(195)),   32'd4);
        check("pin_addr_hblank",  32'(m_addr(193)),   32'd3);
        check("pin_hs_fall",      32'(m_hs(40, 2)),   32'h0);
        check("pin_hs_before",    32'(m_hs(39, 2)),   32'h1);
        check("pin_fs_wrap",      32'(m_fs(576)),     32'h1);
        check("pin_fs_quiet",     32'(m_fs(574)),     32'h0);

        repeat (3) @(negedge clk);
        check_reset("full", {r_f, g_f, b_f}, vga_hs_f, vga_vs_f, rd_en_f, rd_addr_f, fs_f);
        rst = 1'b0;

        // Run into the middle of a full-size line (h_cnt ~ 300), then reset
        // asynchronously between clock edges.
        repeat (610) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset("full_mid", {r_f, g_f, b_f}, vga_hs_f, vga_vs_f, rd_en_f, rd_addr_f, fs_f);
        check_reset("s1_mid", {r_s1, g_s1, b_s1}, hs_s1, vs_s1, rd_en_s1, rd_addr_s1, fs_s1);
        check_reset("s2_mid", {r_s2, g_s2, b_s2}, hs_s2, vs_s2, rd_en_s2, rd_addr_s2, fs_s2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        second_run = 1'b1;

        // Pixel (4,4) of the full-size instance is ticked on edge 2*(4*800+4+1)
        while (n < 6409) @(negedge clk);
        check("full_rd_en_pre", 32'(rd_en_f), 32'h0);
        @(negedge clk);
        check("full_rd_en_44",  32'(rd_en_f),   32'h1);
        check("full_addr_44",   32'(rd_addr_f), 32'd161);
        @(negedge clk);
        check("full_rgb_34",    32'({r_f, g_f, b_f}), 32'h0A0);
        check("full_addr_hold", 32'(rd_addr_f),       32'd161);
        @(negedge clk);
        check("full_rgb_44",    32'({r_f, g_f, b_f}), 32'h0A1);
        check("full_hs_44",     32'(vga_hs_f),        32'h1);
        check("full_vs_44",     32'(vga_vs_f),        32'h1);
        check("full_fs_none",   32'(fs_f),            32'h0);

        // hsync: falls after edge 656*2+2, low 192 clk, line period 1600 clk
        check("full_hs_fall0", 32'(q_at(hs_fall_q, 0)), 32'd1316);
        check("full_hs_rise0", 32'(q_at(hs_rise_q, 0)), 32'd1508);
        check("full_hs_fall1", 32'(q_at(hs_fall_q, 1)), 32'd2916);
        check("full_hs_rise1", 32'(q_at(hs_rise_q, 1)), 32'd3108);

        // One shrunken frame: 16x8 visible pixels, each of 8 words read 16 times
        check("s1_rden_per_frame", 32'(rden_cnt), 32'd128);
        check("s1_rden_bad_addr",  32'(bad_addr), 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("s1_reads_addr%0d", i), 32'(addr_cnt[i]), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
